// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hyperdimensional-computing constants and helpers.
package hdc_pkg;
  localparam int DIMENSIONS = 5;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
  // Majority of n votes with tot ones; an exact tie takes the tie bit.
  function automatic logic maj_bit(input int tot, input int n, input logic tie);
    return (2 * tot > n) ? 1'b1 : (2 * tot < n) ? 1'b0 : tie;
  endfunction
endpackage

// File: rtl/bundler_bit_hf.sv
// bundler_bit_hf: one dimension of the bundler: vote counter, final-sum compare and tie mux.
module bundler_bit_hf #(
  parameter int CHANNELS = 3
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic acc,
  input  logic fin,
  input  logic hv_bit,
  input  logic tie,
  output logic maj
);
  import hdc_pkg::*;
  localparam int CW = cnt_width(CHANNELS);
  logic [CW-1:0] cnt;
  logic [CW:0] tot;
  always_comb begin
    tot = {1'b0, cnt} + {{CW{1'b0}}, hv_bit};
    maj = maj_bit(int'(tot), CHANNELS, tie);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else if (clr || (acc && fin)) cnt <= '0;
    else if (acc) cnt <= tot[CW-1:0];
endmodule

// File: rtl/bundler_hf.sv
// bundler_hf: accumulates CHANNELS bound hypervectors and emits their bitwise majority with a one-cycle strobe.
module bundler_hf #(
  parameter int DIMENSIONS = hdc_pkg::DIMENSIONS,
  parameter int CHANNELS   = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [DIMENSIONS-1:0] hv_in,
  output logic                  out,
  output logic [DIMENSIONS-1:0] hv_out,
  output logic                  busy
);
  import hdc_pkg::*;
  localparam int CW = cnt_width(CHANNELS);
  logic [CW-1:0] n_acc;
  logic [DIMENSIONS-1:0] first_hv, tie, maj;
  logic acc, fin;
  // With an empty window the incoming sample is its own tie source.
  always_comb begin
    acc  = en & ~clr;
    fin  = n_acc == CW'(CHANNELS - 1);
    tie  = (n_acc == '0) ? hv_in : first_hv;
    busy = n_acc != '0;
  end
  genvar i;
  generate
    for (i = 0; i < DIMENSIONS; i++) begin : g_bit
      bundler_bit_hf #(.CHANNELS(CHANNELS)) u_bit (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (clr),
        .acc   (acc),
        .fin   (fin),
        .hv_bit(hv_in[i]),
        .tie   (tie[i]),
        .maj   (maj[i])
      );
    end
  endgenerate
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      n_acc    <= '0;
      first_hv <= '0;
      hv_out   <= '0;
      out      <= 1'b0;
    end else begin
      out <= acc & fin;
      if (clr) begin
        n_acc    <= '0;
        first_hv <= '0;
      end else if (en && fin) begin
        n_acc    <= '0;
        first_hv <= '0;
        hv_out   <= maj;
      end else if (en) begin
        n_acc <= n_acc + CW'(1);
        if (n_acc == '0) first_hv <= hv_in;
      end
    end
endmodule

// File: tb/tb_bundler_hf.sv
// tb_bundler_hf: directed and randomized checks of bundler_hf at CHANNELS=3 and CHANNELS=2 against a window-queue model.
module tb_bundler_hf;
  logic clk = 1'b1;
  logic nrst, en, clr;
  logic [4:0] hv_in;
  logic out3, out2, busy3, busy2;
  logic [4:0] hv3, hv2;
  int checks = 0;
  int errors = 0;

  bundler_hf #(.DIMENSIONS(5), .CHANNELS(3)) u3 (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr), .hv_in(hv_in),
    .out(out3), .hv_out(hv3), .busy(busy3)
  );
  bundler_hf #(.DIMENSIONS(5), .CHANNELS(2)) u2 (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr), .hv_in(hv_in),
    .out(out2), .hv_out(hv2), .busy(busy2)
  );

  always #5 clk = ~clk;

  logic [4:0] q3[$], q2[$];
  logic [4:0] e_hv3 = '0, e_hv2 = '0;
  logic e_out3 = 1'b0, e_out2 = 1'b0;

  function automatic logic [4:0] majority(input logic [4:0] q[$], input int c);
    logic [4:0] r;
    for (int d = 0; d < 5; d++) begin
      int ones = 0;
      foreach (q[k]) ones += int'(q[k][d]);
      r[d] = (2 * ones > c) ? 1'b1 : (2 * ones < c) ? 1'b0 : q[0][d];
    end
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q3.delete(); q2.delete();
      e_hv3 = '0; e_hv2 = '0; e_out3 = 0; e_out2 = 0;
    end else begin
      e_out3 = 0; e_out2 = 0;
      if (clr) begin
        q3.delete(); q2.delete();
      end else if (en) begin
        q3.push_back(hv_in);
        q2.push_back(hv_in);
        if (q3.size() == 3) begin e_hv3 = majority(q3, 3); e_out3 = 1; q3.delete(); end
        if (q2.size() == 2) begin e_hv2 = majority(q2, 2); e_out2 = 1; q2.delete(); end
      end
    end
  end

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out3", 5'(out3), 5'(e_out3));
    chk("hv3", hv3, e_hv3);
    chk("busy3", 5'(busy3), 5'(q3.size() != 0));
    chk("out2", 5'(out2), 5'(e_out2));
    chk("hv2", hv2, e_hv2);
    chk("busy2", 5'(busy2), 5'(q2.size() != 0));
  end

  task automatic cyc(input logic e, input logic c, input logic [4:0] h);
    en = e; clr = c; hv_in = h;
    @(posedge clk); #3;
    en = 0; clr = 0; hv_in = 5'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 5'($urandom));
  endtask

  task automatic pulse_rst();
    #3 nrst = 0;
    #1;
    chk("rst_out3", 5'(out3), 5'd0);
    chk("rst_hv3", hv3, 5'b00000);
    chk("rst_busy3", 5'(busy3), 5'd0);
    chk("rst_busy2", 5'(busy2), 5'd0);
    #1 nrst = 1;
    @(posedge clk); #3;
  endtask

  initial begin
    nrst = 0; en = 0; clr = 0; hv_in = '0;
    #105 nrst = 1;
    #1;
    chk("init_out", 5'(out3), 5'd0);
    chk("init_hv", hv3, 5'b00000);
    chk("init_busy", 5'(busy3), 5'd0);
    @(posedge clk); #3;
    // three accepts 100 ns apart
    cyc(1, 0, 5'b11101);
    chk("s1_busy", 5'(busy3), 5'd1);
    idle(9);
    cyc(1, 0, 5'b10010);
    idle(9);
    chk("s1_busy_mid", 5'(busy3), 5'd1);
    cyc(1, 0, 5'b00111);
    chk("s1_out", 5'(out3), 5'd1);
    chk("s1_hv", hv3, 5'b10111);
    chk("s1_busy_end", 5'(busy3), 5'd0);
    cyc(0, 0, 5'b00000);
    chk("s1_out_drop", 5'(out3), 5'd0);
    chk("s1_hv_hold", hv3, 5'b10111);
    // tie rule on the two-channel instance
    pulse_rst();
    cyc(1, 0, 5'b11100);
    cyc(1, 0, 5'b01010);
    chk("tie_out", 5'(out2), 5'd1);
    chk("tie_hv", hv2, 5'b11100);
    // back-to-back windows
    pulse_rst();
    cyc(1, 0, 5'b11111);
    cyc(1, 0, 5'b11111);
    cyc(1, 0, 5'b00000);
    chk("b2b_out1", 5'(out3), 5'd1);
    chk("b2b_hv1", hv3, 5'b11111);
    cyc(1, 0, 5'b00000);
    chk("b2b_gap", 5'(out3), 5'd0);
    cyc(1, 0, 5'b00000);
    cyc(1, 0, 5'b11111);
    chk("b2b_out2", 5'(out3), 5'd1);
    chk("b2b_hv2", hv3, 5'b00000);
    // abort with clr on the would-be final sample
    pulse_rst();
    repeat (3) cyc(1, 0, 5'b11111);
    chk("ab_pre", hv3, 5'b11111);
    cyc(1, 0, 5'b11111);
    cyc(1, 0, 5'b11111);
    cyc(1, 1, 5'b11111);
    chk("ab_out", 5'(out3), 5'd0);
    chk("ab_hv", hv3, 5'b11111);
    chk("ab_busy", 5'(busy3), 5'd0);
    repeat (3) cyc(1, 0, 5'b00000);
    chk("ab_next", hv3, 5'b00000);
    // reset mid-window
    repeat (3) cyc(1, 0, 5'b11111);
    cyc(1, 0, 5'b11111);
    cyc(1, 0, 5'b11111);
    pulse_rst();
    repeat (3) cyc(1, 0, 5'b01010);
    chk("rm_out", 5'(out3), 5'd1);
    chk("rm_hv", hv3, 5'b01010);
    // idle with toggling input
    idle(20);
    chk("idle_hv", hv3, 5'b01010);
    chk("idle_busy", 5'(busy3), 5'd0);
    // randomized traffic
    repeat (3000) begin
      int r = $urandom_range(0, 199);
      if (r == 0) pulse_rst();
      else cyc(r < 120, r >= 186, 5'($urandom));
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
